// File: rtl/mem_stage_dm.sv
// rtl/mem_stage_dm.sv - MEM-stage data memory with extended loads, byte/half/word stores and store trace
module mem_stage_dm #(
    parameter int DEPTH_WORDS = 3072,
    parameter int IDX_W       = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_MEM,
    input  logic [31:0] Pc4_MEM,
    input  logic [31:0] ALUout_MEM,
    input  logic [31:0] WriteData_MEM,
    output logic [31:0] ReadData_MEM,
    output logic        AddrErr_MEM,
    output logic        st_valid,
    output logic [31:0] st_pc,
    output logic [31:0] st_addr,
    output logic [31:0] st_data
);

    localparam logic [5:0]  OP_LB  = 6'h20;
    localparam logic [5:0]  OP_LH  = 6'h21;
    localparam logic [5:0]  OP_LW  = 6'h23;
    localparam logic [5:0]  OP_LBU = 6'h24;
    localparam logic [5:0]  OP_LHU = 6'h25;
    localparam logic [5:0]  OP_SB  = 6'h28;
    localparam logic [5:0]  OP_SH  = 6'h29;
    localparam logic [5:0]  OP_SW  = 6'h2B;
    localparam logic [31:0] LIMIT  = 32'(4 * DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic [5:0]       op;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             is_load;
    logic             is_store;
    logic             is_word;
    logic             is_half;
    logic             out_of_range;
    logic             misaligned;
    logic             legal_load;
    logic             legal_store;
    logic [31:0]      cur_word;
    logic [31:0]      merged;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic             unused_instr;

    assign op  = Instr_MEM[31:26];
    assign idx = ALUout_MEM[IDX_W+1:2];
    assign off = ALUout_MEM[1:0];
    assign unused_instr = ^Instr_MEM[25:0];

    // Opcode decode and address legality
    always_comb begin
        is_load  = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
                   (op == OP_LBU) || (op == OP_LHU);
        is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        is_word  = (op == OP_LW) || (op == OP_SW);
        is_half  = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        out_of_range = (ALUout_MEM >= LIMIT);
        misaligned   = (is_word && (off != 2'b00)) || (is_half && off[0]);
        legal_load   = is_load && !out_of_range && !misaligned;
        legal_store  = is_store && !out_of_range && !misaligned;
        AddrErr_MEM  = (is_load || is_store) && (out_of_range || misaligned);
    end

    // Current word; out-of-range indices never reach the array
    assign cur_word = out_of_range ? 32'h0 : mem[idx];

    // Lane selection shared by loads
    always_comb begin
        sel_half = off[1] ? cur_word[31:16] : cur_word[15:0];
        case (off)
            2'd0:    sel_byte = cur_word[7:0];
            2'd1:    sel_byte = cur_word[15:8];
            2'd2:    sel_byte = cur_word[23:16];
            default: sel_byte = cur_word[31:24];
        endcase
    end

    // Load extension; zero whenever the access is not a legal load
    always_comb begin
        ReadData_MEM = 32'h0;
        if (legal_load) begin
            case (op)
                OP_LW:   ReadData_MEM = cur_word;
                OP_LB:   ReadData_MEM = {{24{sel_byte[7]}}, sel_byte};
                OP_LBU:  ReadData_MEM = {24'h0, sel_byte};
                OP_LH:   ReadData_MEM = {{16{sel_half[15]}}, sel_half};
                OP_LHU:  ReadData_MEM = {16'h0, sel_half};
                default: ReadData_MEM = 32'h0;
            endcase
        end
    end

    // Merge the store data into the addressed word lane by lane
    always_comb begin
        merged = cur_word;
        case (op)
            OP_SW: merged = WriteData_MEM;
            OP_SH: begin
                if (off[1]) merged[31:16] = WriteData_MEM[15:0];
                else        merged[15:0]  = WriteData_MEM[15:0];
            end
            OP_SB: begin
                case (off)
                    2'd0:    merged[7:0]   = WriteData_MEM[7:0];
                    2'd1:    merged[15:8]  = WriteData_MEM[7:0];
                    2'd2:    merged[23:16] = WriteData_MEM[7:0];
                    default: merged[31:24] = WriteData_MEM[7:0];
                endcase
            end
            default: merged = cur_word;
        endcase
    end

    // Array update: reset clears every word and wins over a same-cycle store
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (legal_store) begin
            mem[idx] <= merged;
        end
    end

    // Store trace: pulse per committed store, payload held otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid <= 1'b0;
            st_pc    <= 32'h0;
            st_addr  <= 32'h0;
            st_data  <= 32'h0;
        end else begin
            st_valid <= legal_store;
            if (legal_store) begin
                st_pc   <= Pc4_MEM - 32'd4;
                st_addr <= {ALUout_MEM[31:2], 2'b00};
                st_data <= merged;
            end
        end
    end

endmodule
